// File: rtl/wishbone_classic_gpio_multi_pkg.sv
// wishbone_gpio_pkg
// Shared definitions for the multi-bank Wishbone GPIO slave: the per-bank
// register offsets, the bank stride, the global interrupt enable address,
// the register selector decoded from addr[4:2] and the bus response states.
package wishbone_gpio_pkg;

  localparam int unsigned CHANNEL_STRIDE = 32'h20;
  localparam int unsigned GIE_ADDR       = 32'h100;

  localparam logic [4:0] OFF_DATA       = 5'h00;
  localparam logic [4:0] OFF_TRI        = 5'h04;
  localparam logic [4:0] OFF_SET        = 5'h08;
  localparam logic [4:0] OFF_CLR        = 5'h0C;
  localparam logic [4:0] OFF_RISE_EN    = 5'h10;
  localparam logic [4:0] OFF_FALL_EN    = 5'h14;
  localparam logic [4:0] OFF_IRQ_STATUS = 5'h18;
  localparam logic [4:0] OFF_RESERVED   = 5'h1C;

  // Register selector, equal to the word index of the offset inside a bank
  typedef enum logic [2:0] {
    REG_DATA   = 3'd0,
    REG_TRI    = 3'd1,
    REG_SET    = 3'd2,
    REG_CLR    = 3'd3,
    REG_RISE   = 3'd4,
    REG_FALL   = 3'd5,
    REG_STATUS = 3'd6,
    REG_RSVD   = 3'd7
  } reg_sel_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } bus_state_t;

endpackage

// File: rtl/wishbone_classic_gpio_multi_if.sv
// wishbone_classic_gpio_multi_if
// Wishbone classic bus bundle between the peripheral master and the GPIO slave.
//   cyc, stb, we  : cycle, strobe, write enable (master -> slave)
//   addr          : byte address (master -> slave)
//   data_i, sel   : write data and byte lane enables (master -> slave)
//   ack, err      : transfer acknowledge / error acknowledge (slave -> master)
//   data_o        : read data (slave -> master)
interface wishbone_classic_gpio_multi_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int BUS_WIDTH     = 4
);
  logic                     cyc;
  logic                     stb;
  logic                     we;
  logic [ADDRESS_WIDTH-1:0] addr;
  logic [BUS_WIDTH*8-1:0]   data_i;
  logic [BUS_WIDTH-1:0]     sel;
  logic                     ack;
  logic [BUS_WIDTH*8-1:0]   data_o;
  logic                     err;

  modport master (output cyc, stb, we, addr, data_i, sel, input ack, data_o, err);
  modport slave  (input cyc, stb, we, addr, data_i, sel, output ack, data_o, err);
endinterface

// File: rtl/wishbone_classic_gpio_multi_gpio_channel.sv
// gpio_channel
// One GPIO bank: output and tristate registers, atomic set/clear, an input
// synchroniser, per-bit rising/falling edge detection and the sticky status.
//   clk, rst     : clock, asynchronous active-high reset
//   wr_en        : commit a write to the register chosen by reg_sel this edge
//   reg_sel      : register addressed by the current bus access
//   wr_data      : write data, wr_mask: byte-lane expanded write mask
//   rd_data      : combinational read value of the register chosen by reg_sel
//   pins         : raw pin inputs, pin_out/pin_tri: output value / tristate
//   irq_pending  : any status bit set
module gpio_channel
  import wishbone_gpio_pkg::*;
#(
  parameter int GPIO_WIDTH  = 32,
  parameter int BUS_WIDTH   = 4,
  parameter int SYNC_STAGES = 2,
  parameter int IRQ_ENABLE  = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  reg_sel_t               reg_sel,
  input  logic [GPIO_WIDTH-1:0]  wr_data,
  input  logic [GPIO_WIDTH-1:0]  wr_mask,
  output logic [BUS_WIDTH*8-1:0] rd_data,
  input  logic [GPIO_WIDTH-1:0]  pins,
  output logic [GPIO_WIDTH-1:0]  pin_out,
  output logic [GPIO_WIDTH-1:0]  pin_tri,
  output logic                   irq_pending
);

  logic [GPIO_WIDTH-1:0]  out_q, tri_q, rise_q, fall_q, stat_q, prev_q;
  logic [GPIO_WIDTH-1:0]  sync_q [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] vld_q;
  logic                   prev_vld_q;
  logic [GPIO_WIDTH-1:0]  sample, wdata, w1c, edges;

  assign sample      = sync_q[SYNC_STAGES-1];
  assign wdata       = wr_data & wr_mask;
  assign w1c         = (wr_en && reg_sel == REG_STATUS) ? wdata : '0;
  assign pin_out     = out_q;
  assign pin_tri     = tri_q;
  assign irq_pending = |stat_q;

  // vld_q travels alongside the data so that an edge is only reported once
  // both the current and the previous sample came from real pin values
  always_comb begin
    edges = '0;
    if (prev_vld_q && vld_q[SYNC_STAGES-1]) begin
      edges = (sample & ~prev_q & rise_q) | (~sample & prev_q & fall_q);
    end
  end

  // Input synchroniser and previous-sample register for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      vld_q      <= '0;
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
    end else begin
      sync_q[0] <= pins;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      vld_q      <= {vld_q[SYNC_STAGES-2:0], 1'b1};
      prev_q     <= sample;
      prev_vld_q <= vld_q[SYNC_STAGES-1];
    end
  end

  // Bank registers; a new edge outranks a same-cycle W1C of the same bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q  <= '0;
      tri_q  <= '1;
      rise_q <= '0;
      fall_q <= '0;
      stat_q <= '0;
    end else begin
      if (wr_en) begin
        case (reg_sel)
          REG_DATA: out_q <= (out_q & ~wr_mask) | wdata;
          REG_TRI:  tri_q <= (tri_q & ~wr_mask) | wdata;
          REG_SET:  out_q <= out_q | wdata;
          REG_CLR:  out_q <= out_q & ~wdata;
          REG_RISE: if (IRQ_ENABLE != 0) rise_q <= (rise_q & ~wr_mask) | wdata;
          REG_FALL: if (IRQ_ENABLE != 0) fall_q <= (fall_q & ~wr_mask) | wdata;
          default: ;
        endcase
      end
      if (IRQ_ENABLE != 0) stat_q <= (stat_q & ~w1c) | edges;
    end
  end

  // Read mux; SET, CLR and the reserved word read as zero
  always_comb begin
    rd_data = '0;
    case (reg_sel)
      REG_DATA:   rd_data[GPIO_WIDTH-1:0] = sample;
      REG_TRI:    rd_data[GPIO_WIDTH-1:0] = tri_q;
      REG_RISE:   rd_data[GPIO_WIDTH-1:0] = rise_q;
      REG_FALL:   rd_data[GPIO_WIDTH-1:0] = fall_q;
      REG_STATUS: rd_data[GPIO_WIDTH-1:0] = stat_q;
      default: ;
    endcase
  end

endmodule

// File: rtl/wishbone_classic_gpio_multi.sv
// wishbone_classic_gpio_multi
// Wishbone classic slave with CHANNELS GPIO banks at a 0x20 stride plus a
// global interrupt enable at 0x100; one combined, registered irq output.
//   clk, rst   : clock, asynchronous active-high reset
//   s_wb       : Wishbone classic slave port (interface, slave modport)
//   irq        : level interrupt, GIE & any bank status bit, registered
//   gpio_io_i  : pins, bank c at [c*GPIO_WIDTH +: GPIO_WIDTH]
//   gpio_io_o  : output values, gpio_io_t: tristate (1 = input)
module wishbone_classic_gpio_multi
  import wishbone_gpio_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int BUS_WIDTH     = 4,
  parameter int GPIO_WIDTH    = 32,
  parameter int CHANNELS      = 2,
  parameter int IRQ_ENABLE    = 1,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  wishbone_classic_gpio_multi_if.slave   s_wb,
  output logic                           irq,
  input  logic [CHANNELS*GPIO_WIDTH-1:0] gpio_io_i,
  output logic [CHANNELS*GPIO_WIDTH-1:0] gpio_io_o,
  output logic [CHANNELS*GPIO_WIDTH-1:0] gpio_io_t
);

  localparam int DW = BUS_WIDTH * 8;

  bus_state_t          state;
  reg_sel_t            reg_sel;
  logic                req, misaligned, chan_space, gie_hit, bad, gie_q;
  logic [DW-1:0]       byte_mask, rd_mux;
  logic [DW-1:0]       chan_rd [CHANNELS];
  logic [CHANNELS-1:0] chan_hit, pending;

  // Only an idle slave accepts a request, so a held stb yields an ack every other cycle
  assign req        = s_wb.cyc && s_wb.stb && state == ST_IDLE;
  assign misaligned = s_wb.addr[1:0] != 2'b00;
  assign chan_space = s_wb.addr < ADDRESS_WIDTH'(CHANNELS * CHANNEL_STRIDE);
  assign gie_hit    = s_wb.addr == ADDRESS_WIDTH'(GIE_ADDR);
  assign bad        = misaligned || !(chan_space || gie_hit);
  assign reg_sel    = reg_sel_t'(s_wb.addr[4:2]);

  // Address decode to banks and byte-lane expansion of sel
  always_comb begin
    chan_hit = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      chan_hit[c] = chan_space && !misaligned && s_wb.addr[7:5] == 3'(c);
    end
    byte_mask = '0;
    for (int b = 0; b < BUS_WIDTH; b++) begin
      byte_mask[b*8 +: 8] = {8{s_wb.sel[b]}};
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    gpio_channel #(
      .GPIO_WIDTH (GPIO_WIDTH),
      .BUS_WIDTH  (BUS_WIDTH),
      .SYNC_STAGES(SYNC_STAGES),
      .IRQ_ENABLE (IRQ_ENABLE)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .wr_en      (req && s_wb.we && chan_hit[c]),
      .reg_sel    (reg_sel),
      .wr_data    (s_wb.data_i[GPIO_WIDTH-1:0]),
      .wr_mask    (byte_mask[GPIO_WIDTH-1:0]),
      .rd_data    (chan_rd[c]),
      .pins       (gpio_io_i[c*GPIO_WIDTH +: GPIO_WIDTH]),
      .pin_out    (gpio_io_o[c*GPIO_WIDTH +: GPIO_WIDTH]),
      .pin_tri    (gpio_io_t[c*GPIO_WIDTH +: GPIO_WIDTH]),
      .irq_pending(pending[c])
    );
  end

  // Read mux across the banks and the GIE word
  always_comb begin
    rd_mux = '0;
    if (gie_hit) rd_mux[0] = gie_q;
    for (int c = 0; c < CHANNELS; c++) begin
      if (chan_hit[c]) rd_mux = rd_mux | chan_rd[c];
    end
  end

  // Response FSM: ack/err and read data registered for one cycle; GIE and irq
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      s_wb.ack    <= 1'b0;
      s_wb.err    <= 1'b0;
      s_wb.data_o <= '0;
      gie_q       <= 1'b0;
      irq         <= 1'b0;
    end else begin
      irq <= (IRQ_ENABLE != 0) && gie_q && (|pending);
      case (state)
        ST_IDLE: begin
          if (s_wb.cyc && s_wb.stb) begin
            state       <= ST_RESP;
            s_wb.ack    <= !bad;
            s_wb.err    <= bad;
            s_wb.data_o <= (!bad && !s_wb.we) ? rd_mux : '0;
            if (!bad && s_wb.we && gie_hit && IRQ_ENABLE != 0 && s_wb.sel[0]) begin
              gie_q <= s_wb.data_i[0];
            end
          end
        end
        default: begin
          state       <= ST_IDLE;
          s_wb.ack    <= 1'b0;
          s_wb.err    <= 1'b0;
          s_wb.data_o <= '0;
        end
      endcase
    end
  end

endmodule
